// File: rtl/rng_ctrl.sv
// rng_ctrl: bus controller for the 16-bit Fibonacci LFSR random source.
// Define RNG_IRQ_EN to add the registered IRQ output (VALID-rise interrupt).
module rng_ctrl #(
    parameter logic [15:0] SEED      = 16'hBABE,
    parameter int          MIX_STEPS = 8,
    parameter int          CNT_W     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       CS,
    input  logic       WE,
    input  logic [1:0] ADDR,
    input  logic [7:0] DI,
    output logic [7:0] DO
`ifdef RNG_IRQ_EN
    ,
    output logic       IRQ
`endif
);

    typedef enum logic {
        IDLE,
        MIX
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MIX_STEPS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [15:0]      lfsr;
    logic [7:0]       hi_latch;
    logic [7:0]       seed_lo;
    logic [CNT_W-1:0] cnt;
    logic             valid;
    logic             underrun;
    logic             run;
    logic             ie;
    logic             seed_phase;

    logic             rd;
    logic             wr;
    logic             rd_lo;
    logic             rd_st;
    logic             wr_ctl;
    logic             wr_seed;
    logic             seed_load;
    logic [15:0]      seed_word;
    logic [15:0]      lfsr_step;
`ifdef RNG_IRQ_EN
    logic             ie_nxt;
`endif

    // Bus strobe decode, seed word selection and next LFSR value.
    always_comb begin
        rd        = CS & ~WE;
        wr        = CS & WE;
        rd_lo     = rd && (ADDR == 2'd0);
        rd_st     = rd && (ADDR == 2'd2);
        wr_ctl    = wr && (ADDR == 2'd2);
        wr_seed   = wr && (ADDR == 2'd3);
        seed_load = wr_seed & seed_phase;
        seed_word = {DI, seed_lo};
        if (seed_word == 16'h0000)
            seed_word = SEED;
        lfsr_step = {lfsr[14:0],
                     lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`ifdef RNG_IRQ_EN
        ie_nxt    = wr_ctl ? DI[1] : ie;
`endif
    end

    // Read mux; low byte is live, high byte comes from the read latch.
    always_comb begin
        case (ADDR)
            2'd0:    DO = lfsr[7:0];
            2'd1:    DO = hi_latch;
            2'd2:    DO = {valid, underrun, seed_phase, 3'b000, ie, run};
            default: DO = seed_lo;
        endcase
    end

    // Controller FSM: owns LFSR stepping, mix burst, status and seeding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lfsr       <= SEED;
            hi_latch   <= SEED[15:8];
            seed_lo    <= 8'h00;
            cnt        <= '0;
            valid      <= 1'b1;
            underrun   <= 1'b0;
            run        <= 1'b0;
            ie         <= 1'b0;
            seed_phase <= 1'b0;
`ifdef RNG_IRQ_EN
            IRQ        <= 1'b0;
`endif
        end else begin
            // Status read clears underrun; a same-edge set below wins.
            if (rd_st)
                underrun <= 1'b0;

            if (wr_ctl) begin
                run <= DI[0];
                ie  <= DI[1];
            end

            if (wr_seed) begin
                if (!seed_phase) begin
                    seed_lo    <= DI;
                    seed_phase <= 1'b1;
                end else begin
                    seed_phase <= 1'b0;
                end
            end

`ifdef RNG_IRQ_EN
            if (rd_lo || (wr_ctl && !DI[1]))
                IRQ <= 1'b0;
`endif

            case (state)
                IDLE: begin
                    if (seed_load) begin
                        lfsr     <= seed_word;
                        hi_latch <= seed_word[15:8];
                    end else if (run || (wr_ctl && DI[2])) begin
                        lfsr <= lfsr_step;
                    end
                    if (rd_lo) begin
                        hi_latch <= lfsr[15:8];
                        if (!run) begin
                            state <= MIX;
                            cnt   <= CNT_INIT;
                            valid <= 1'b0;
                        end
                    end
                end

                MIX: begin
                    // A seed load replaces this cycle's step.
                    if (seed_load) begin
                        lfsr     <= seed_word;
                        hi_latch <= seed_word[15:8];
                    end else begin
                        lfsr <= lfsr_step;
                    end

                    if (wr_ctl && DI[0]) begin
                        state <= IDLE;
                        valid <= 1'b1;
                        cnt   <= '0;
`ifdef RNG_IRQ_EN
                        if (ie_nxt)
                            IRQ <= 1'b1;
`endif
                    end else if (rd_lo) begin
                        underrun <= 1'b1;
                        hi_latch <= lfsr[15:8];
                        cnt      <= CNT_INIT;
                    end else if (seed_load) begin
                        cnt <= CNT_INIT;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            state <= IDLE;
                            valid <= 1'b1;
`ifdef RNG_IRQ_EN
                            if (ie_nxt)
                                IRQ <= 1'b1;
`endif
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    valid <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_ctrl.sv
// tb_rng_ctrl: randomized and directed checks of rng_ctrl against
// a cycle-level behavioural model (two instances: 8-step and 1-step mix).
module tb_rng_ctrl;

    localparam int          N    = 8;
    localparam logic [15:0] SEED = 16'hBABE;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs8 = 1'b0;
    logic       cs1 = 1'b0;
    logic       WE = 1'b0;
    logic [1:0] ADDR = 2'd0;
    logic [7:0] DI = 8'h00;
    logic [7:0] do8;
    logic [7:0] do1;
`ifdef RNG_IRQ_EN
    logic       irq8;
    logic       irq1;
`endif

    int checks = 0;
    int errors = 0;

    // model state: mix_left counts remaining mix steps (0 means VALID)
    logic [15:0] m_lfsr;
    logic [7:0]  m_hi;
    logic [7:0]  m_slo;
    int          m_left;
    logic        m_und;
    logic        m_run;
    logic        m_ie;
    logic        m_phase;
    logic        m_irq;

    always #5 clk = ~clk;

    rng_ctrl #(.SEED(SEED), .MIX_STEPS(N), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .CS(cs8), .WE(WE),
        .ADDR(ADDR), .DI(DI), .DO(do8)
`ifdef RNG_IRQ_EN
        , .IRQ(irq8)
`endif
    );

    rng_ctrl #(.SEED(SEED), .MIX_STEPS(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .CS(cs1), .WE(WE),
        .ADDR(ADDR), .DI(DI), .DO(do1)
`ifdef RNG_IRQ_EN
        , .IRQ(irq1)
`endif
    );

    function automatic logic [15:0] lstep(input logic [15:0] v);
        logic fb;
        fb = ^(v & 16'hB400);
        return (v << 1) | 16'(fb);
    endfunction

    function automatic logic [7:0] model_do(input logic [1:0] a);
        logic [7:0] s;
        s = {(m_left == 0), m_und, m_phase, 3'b000, m_ie, m_run};
        case (a)
            2'd0:    return m_lfsr[7:0];
            2'd1:    return m_hi;
            2'd2:    return s;
            default: return m_slo;
        endcase
    endfunction

    task automatic model_reset;
        m_lfsr  = SEED;
        m_hi    = SEED[15:8];
        m_slo   = 8'h00;
        m_left  = 0;
        m_und   = 1'b0;
        m_run   = 1'b0;
        m_ie    = 1'b0;
        m_phase = 1'b0;
        m_irq   = 1'b0;
    endtask

    task automatic model_clock;
        logic rd, wr, rd0, wr2, busy, load;
        logic [15:0] sw;
        logic [15:0] n_lfsr;
        logic [7:0] n_hi, n_slo;
        int n_left;
        logic n_und, n_run, n_ie, n_phase, n_irq;
        rd   = cs8 && !WE;
        wr   = cs8 && WE;
        rd0  = rd && ADDR == 2'd0;
        wr2  = wr && ADDR == 2'd2;
        busy = (m_left != 0);
        load = wr && ADDR == 2'd3 && m_phase;
        n_lfsr = m_lfsr; n_hi = m_hi; n_slo = m_slo; n_left = m_left;
        n_und = m_und; n_run = m_run; n_ie = m_ie;
        n_phase = m_phase; n_irq = m_irq;
        if (rd && ADDR == 2'd2) n_und = 1'b0;
        if (wr2) begin
            n_run = DI[0];
            n_ie  = DI[1];
        end
        if (wr && ADDR == 2'd3) begin
            if (!m_phase) begin
                n_slo   = DI;
                n_phase = 1'b1;
            end else begin
                n_phase = 1'b0;
            end
        end
        if (load) begin
            sw = {DI, m_slo};
            if (sw == 16'h0) sw = SEED;
            n_lfsr = sw;
            n_hi   = sw[15:8];
        end else if (busy || m_run || (wr2 && DI[2])) begin
            n_lfsr = lstep(m_lfsr);
        end
        if (busy) begin
            if (wr2 && DI[0]) n_left = 0;
            else if (rd0) begin
                n_und  = 1'b1;
                n_hi   = m_lfsr[15:8];
                n_left = N;
            end else if (load) n_left = N;
            else n_left = m_left - 1;
        end else if (rd0) begin
            n_hi = m_lfsr[15:8];
            if (!m_run) n_left = N;
        end
        if (rd0 || (wr2 && !DI[1])) n_irq = 1'b0;
        if (busy && n_left == 0 && n_ie) n_irq = 1'b1;
        m_lfsr = n_lfsr; m_hi = n_hi; m_slo = n_slo; m_left = n_left;
        m_und = n_und; m_run = n_run; m_ie = n_ie;
        m_phase = n_phase; m_irq = n_irq;
    endtask

    task automatic drive(input logic c8, input logic c1, input logic w,
                         input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cs8 = c8; cs1 = c1; WE = w; ADDR = a; DI = d;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        model_clock();
    endtask

    task automatic do_reset;
        @(negedge clk);
        cs8 = 1'b0; cs1 = 1'b0; WE = 1'b0; ADDR = 2'd0; DI = 8'h00;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] exp [4];
        exp[0] = 8'hBE; exp[1] = 8'hBA; exp[2] = 8'h80; exp[3] = 8'h00;
        do_reset();
        for (int a = 0; a < 4; a++) begin
            drive(1'b0, 1'b0, 1'b0, 2'(a), 8'h00);
            checks++;
            if (do8 !== exp[a]) begin
                errors++;
                $display("FAIL reset_do addr %0d got %h want %h", a, do8, exp[a]);
            end
            tick();
        end
    endtask

    task automatic test_mix1;
        logic [1:0] a [6];
        logic [7:0] e [6];
        logic       c [6];
        a[0] = 2'd0; e[0] = 8'hBE; c[0] = 1'b1;
        a[1] = 2'd2; e[1] = 8'h00; c[1] = 1'b0;
        a[2] = 2'd2; e[2] = 8'h80; c[2] = 1'b0;
        a[3] = 2'd1; e[3] = 8'hBA; c[3] = 1'b0;
        a[4] = 2'd0; e[4] = 8'h7D; c[4] = 1'b1;
        a[5] = 2'd1; e[5] = 8'h75; c[5] = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, c[i], 1'b0, a[i], 8'h00);
            checks++;
            if (do1 !== e[i]) begin
                errors++;
                $display("FAIL mix1 step %0d got %h want %h", i, do1, e[i]);
            end
            tick();
        end
    endtask

    task automatic test_underrun;
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00); tick();
        drive(1'b0, 1'b0, 1'b0, 2'd2, 8'h00); tick();
        drive(1'b0, 1'b0, 1'b0, 2'd2, 8'h00); tick();
        drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00); tick();
        drive(1'b1, 1'b0, 1'b0, 2'd2, 8'h00);
        checks++;
        if (do8 !== 8'h40) begin
            errors++;
            $display("FAIL underrun_stat got %h want 40", do8);
        end
        tick();
        drive(1'b1, 1'b0, 1'b0, 2'd2, 8'h00);
        checks++;
        if (do8 !== 8'h00) begin
            errors++;
            $display("FAIL underrun_clr got %h want 00", do8);
        end
        tick();
        for (int k = 2; k <= N + 1; k++) begin
            drive(1'b0, 1'b0, 1'b0, 2'd2, 8'h00);
            checks++;
            if (do8[7] !== (k >= N)) begin
                errors++;
                $display("FAIL underrun_valid k %0d got %b want %b",
                         k, do8[7], (k >= N));
            end
            tick();
        end
    endtask

    task automatic test_seed;
        logic [1:0] a [6];
        logic [7:0] e [6];
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 2'd3, 8'h34); tick();
        a[0] = 2'd2; e[0] = 8'hA0;
        drive(1'b0, 1'b0, 1'b0, a[0], 8'h00);
        checks++;
        if (do8 !== e[0]) begin
            errors++;
            $display("FAIL seed_phase1 got %h want %h", do8, e[0]);
        end
        tick();
        drive(1'b1, 1'b0, 1'b1, 2'd3, 8'h12); tick();
        a[1] = 2'd2; e[1] = 8'h80;
        a[2] = 2'd0; e[2] = 8'h34;
        a[3] = 2'd1; e[3] = 8'h12;
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, a[i], 8'h00);
            checks++;
            if (do8 !== e[i]) begin
                errors++;
                $display("FAIL seed_load %0d got %h want %h", i, do8, e[i]);
            end
            tick();
        end
        drive(1'b1, 1'b0, 1'b1, 2'd3, 8'h00); tick();
        drive(1'b1, 1'b0, 1'b1, 2'd3, 8'h00); tick();
        a[4] = 2'd0; e[4] = 8'hBE;
        a[5] = 2'd1; e[5] = 8'hBA;
        for (int i = 4; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b0, a[i], 8'h00);
            checks++;
            if (do8 !== e[i]) begin
                errors++;
                $display("FAIL seed_zero %0d got %h want %h", i, do8, e[i]);
            end
            tick();
        end
    endtask

    task automatic test_run;
        logic [7:0] e [3];
        e[0] = 8'hBE; e[1] = 8'h7D; e[2] = 8'hFB;
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 2'd2, 8'h01); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
            checks++;
            if (do8 !== e[i]) begin
                errors++;
                $display("FAIL run_seq %0d got %h want %h", i, do8, e[i]);
            end
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00); tick();
        drive(1'b0, 1'b0, 1'b0, 2'd2, 8'h00);
        checks++;
        if (do8 !== 8'h81) begin
            errors++;
            $display("FAIL run_nomix got %h want 81", do8);
        end
        tick();
        drive(1'b1, 1'b0, 1'b1, 2'd2, 8'h00); tick();
    endtask

    task automatic test_step;
        logic [15:0] v;
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 2'd2, 8'h04); tick();
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        checks++;
        if (do8 !== 8'h7D) begin
            errors++;
            $display("FAIL step_idle got %h want 7d", do8);
        end
        tick();
        v = 16'h757D;
        for (int i = 0; i < N; i++) v = lstep(v);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00); tick();
        drive(1'b1, 1'b0, 1'b1, 2'd2, 8'h04); tick();
        for (int j = 2; j <= N; j++) begin
            drive(1'b0, 1'b0, 1'b0, 2'd2, 8'h00); tick();
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        checks++;
        if (do8 !== v[7:0]) begin
            errors++;
            $display("FAIL step_mix got %h want %h", do8, v[7:0]);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 2'd2, 8'h00);
        checks++;
        if (do8 !== 8'h80) begin
            errors++;
            $display("FAIL step_mix_valid got %h want 80", do8);
        end
        tick();
    endtask

    task automatic test_abort;
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00); tick();
        drive(1'b0, 1'b0, 1'b0, 2'd2, 8'h00); tick();
        drive(1'b1, 1'b0, 1'b1, 2'd2, 8'h01); tick();
        drive(1'b0, 1'b0, 1'b0, 2'd2, 8'h00);
        checks++;
        if (do8 !== 8'h81) begin
            errors++;
            $display("FAIL abort_stat got %h want 81", do8);
        end
        tick();
        drive(1'b1, 1'b0, 1'b1, 2'd2, 8'h00); tick();
    endtask

`ifdef RNG_IRQ_EN
    task automatic test_irq;
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 2'd2, 8'h02); tick();
        drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00); tick();
        for (int k = 0; k < N; k++) begin
            drive(1'b0, 1'b0, 1'b0, 2'd2, 8'h00);
            checks++;
            if (irq8 !== 1'b0) begin
                errors++;
                $display("FAIL irq_early k %0d got %b want 0", k, irq8);
            end
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        checks++;
        if (irq8 !== 1'b1) begin
            errors++;
            $display("FAIL irq_rise got %b want 1", irq8);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 2'd2, 8'h00);
        checks++;
        if (irq8 !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear got %b want 0", irq8);
        end
        tick();
    endtask
`endif

    task automatic test_reset_mid_mix;
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 2'd2, 8'h02); tick();
        drive(1'b1, 1'b0, 1'b1, 2'd3, 8'h55); tick();
        drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00); tick();
        drive(1'b0, 1'b0, 1'b0, 2'd2, 8'h00); tick();
        drive(1'b0, 1'b0, 1'b0, 2'd2, 8'h00);
        reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (do8 !== 8'h80) begin
            errors++;
            $display("FAIL reset_mid_mix got %h want 80", do8);
        end
`ifdef RNG_IRQ_EN
        checks++;
        if (irq8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_irq got %b want 0", irq8);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random;
        logic c, w;
        logic [1:0] a;
        logic [7:0] d;
        logic [7:0] e;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            c = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            if (c && w && a == 2'd2)
                d[0] = ($urandom_range(0, 7) == 0);
            drive(c, 1'b0, w, a, d);
            e = model_do(a);
            checks++;
            if (do8 !== e) begin
                errors++;
                $display("FAIL random cyc %0d addr %0d got %h want %h",
                         i, a, do8, e);
            end
`ifdef RNG_IRQ_EN
            checks++;
            if (irq8 !== m_irq) begin
                errors++;
                $display("FAIL random_irq cyc %0d got %b want %b",
                         i, irq8, m_irq);
            end
`endif
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_mix1();
        test_underrun();
        test_seed();
        test_run();
        test_step();
        test_abort();
`ifdef RNG_IRQ_EN
        test_irq();
`endif
        test_reset_mid_mix();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
